// File: rtl/tree_operand_loader.sv
// Serial-to-parallel operand loader for the 8-input adder tree: packs eight words into lanes A..H
// and holds them until acknowledged. Define LOADER_ZERO_PAD_EN to add IN_LAST for short frames.
module tree_operand_loader #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [WIDTH-1:0]     IN_DATA,
    input  logic                 IN_VALID,
`ifdef LOADER_ZERO_PAD_EN
    input  logic                 IN_LAST,
`endif
    output logic                 IN_READY,
    input  logic                 FLUSH,
    input  logic                 FRAME_ACK,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     C,
    output logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     E,
    output logic [WIDTH-1:0]     F,
    output logic [WIDTH-1:0]     G,
    output logic [WIDTH-1:0]     H,
    output logic                 FRAME_VALID,
    output logic [2:0]           FILL_IDX,
    output logic [CNT_WIDTH-1:0] FRAME_CNT
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     lane_q [8];
    logic [2:0]           fill_idx_q;
    logic                 frame_valid_q;
    logic [CNT_WIDTH-1:0] frame_cnt_q;
    logic                 close_early;

`ifdef LOADER_ZERO_PAD_EN
    assign close_early = IN_LAST;
`else
    assign close_early = 1'b0;
`endif

    // In FILL every presented word is taken, so the handshake reduces to IN_VALID there.
    assign IN_READY = (state_q == FILL);

    // NOTE: the lane array is reset explicitly because the spec'd outputs must read 0 after
    // reset, and unwritten lanes must read 0 for zero-padded frames; a plain RAM could not do this.
    // NOTE: all state below uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= FILL;
            fill_idx_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
            for (int i = 0; i < 8; i++) lane_q[i] <= '0;
        end else if (FLUSH) begin
            state_q       <= FILL;
            fill_idx_q    <= '0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) lane_q[i] <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (IN_VALID) begin
                        lane_q[fill_idx_q] <= IN_DATA;
                        if (fill_idx_q == 3'd7 || close_early) begin
                            state_q       <= HOLD;
                            frame_valid_q <= 1'b1;
                            fill_idx_q    <= '0;
                        end else begin
                            fill_idx_q <= fill_idx_q + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    // Lanes are cleared on release so a short frame later sees zeros above its last lane.
                    if (FRAME_ACK) begin
                        state_q       <= FILL;
                        frame_valid_q <= 1'b0;
                        frame_cnt_q   <= frame_cnt_q + CNT_WIDTH'(1);
                        for (int i = 0; i < 8; i++) lane_q[i] <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign A           = lane_q[0];
    assign B           = lane_q[1];
    assign C           = lane_q[2];
    assign D           = lane_q[3];
    assign E           = lane_q[4];
    assign F           = lane_q[5];
    assign G           = lane_q[6];
    assign H           = lane_q[7];
    assign FRAME_VALID = frame_valid_q;
    assign FILL_IDX    = fill_idx_q;
    assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_tree_operand_loader.sv
// Self-checking bench for tree_operand_loader: directed scenarios plus randomized traffic
// compared against a queue-based frame model; a CNT_WIDTH=2 twin checks counter wrap.
module tb_tree_operand_loader;

    localparam int W = 16;

    logic          CLK;
    logic          RST_N;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          flush;
    logic          frame_ack;

    logic          in_ready, in_ready2;
    logic [W-1:0]  a, b, c, d, e, f, g, h;
    logic [W-1:0]  a2, b2, c2, d2, e2, f2, g2, h2;
    logic          frame_valid, frame_valid2;
    logic [2:0]    fill_idx, fill_idx2;
    logic [7:0]    frame_cnt;
    logic [1:0]    frame_cnt2;

    int total = 0;
    int bad   = 0;

    // Reference model: the frame is just the list of words taken so far.
    int m_q[$];
    bit m_hold;
    int m_acks;

    tree_operand_loader #(.WIDTH(W), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(in_data), .IN_VALID(in_valid),
`ifdef LOADER_ZERO_PAD_EN
        .IN_LAST(in_last),
`endif
        .IN_READY(in_ready), .FLUSH(flush), .FRAME_ACK(frame_ack),
        .A(a), .B(b), .C(c), .D(d), .E(e), .F(f), .G(g), .H(h),
        .FRAME_VALID(frame_valid), .FILL_IDX(fill_idx), .FRAME_CNT(frame_cnt)
    );

    tree_operand_loader #(.WIDTH(W), .CNT_WIDTH(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(in_data), .IN_VALID(in_valid),
`ifdef LOADER_ZERO_PAD_EN
        .IN_LAST(in_last),
`endif
        .IN_READY(in_ready2), .FLUSH(flush), .FRAME_ACK(frame_ack),
        .A(a2), .B(b2), .C(c2), .D(d2), .E(e2), .F(f2), .G(g2), .H(h2),
        .FRAME_VALID(frame_valid2), .FILL_IDX(fill_idx2), .FRAME_CNT(frame_cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] dut_lanes();
        return {a, b, c, d, e, f, g, h};
    endfunction

    function automatic logic [127:0] dut2_lanes();
        return {a2, b2, c2, d2, e2, f2, g2, h2};
    endfunction

    function automatic logic [127:0] model_lanes();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (i < m_q.size()) r[127-16*i -: 16] = W'(m_q[i]);
        return r;
    endfunction

    function automatic int dut_sum();
        return int'(a) + int'(b) + int'(c) + int'(d) + int'(e) + int'(f) + int'(g) + int'(h);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold = 1'b0;
        m_acks = 0;
    endtask

    task automatic model_step(input bit v, input int dat, input bit fl, input bit ak, input bit la);
        if (fl) begin
            m_q.delete();
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (v) begin
                m_q.push_back(dat);
                if (m_q.size() == 8 || la) m_hold = 1'b1;
            end
        end else if (ak) begin
            m_q.delete();
            m_hold = 1'b0;
            m_acks++;
        end
    endtask

    task automatic check_all();
        check("lanes", dut_lanes(), model_lanes());
        check("lanes_w2", dut2_lanes(), model_lanes());
        check("frame_valid", 128'(frame_valid), 128'(m_hold));
        check("fill_idx", 128'(fill_idx), m_hold ? 128'd0 : 128'(m_q.size()));
        check("in_ready", 128'(in_ready), 128'(!m_hold));
        check("frame_cnt", 128'(frame_cnt), 128'(m_acks % 256));
        check("frame_cnt_w2", 128'(frame_cnt2), 128'(m_acks % 4));
    endtask

    // One clock: drive inputs, advance model with what the DUT sampled, compare just after the edge.
    task automatic step(input bit v, input int dat, input bit fl, input bit ak, input bit la);
        in_valid  = v;
        in_data   = W'(dat);
        flush     = fl;
        frame_ack = ak;
`ifdef LOADER_ZERO_PAD_EN
        in_last   = la;
`else
        in_last   = 1'b0;
`endif
        @(posedge CLK);
        model_step(v, dat, fl, ak, in_last);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input int dat);
        step(1'b1, dat, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        flush = 1'b0; frame_ack = 1'b0;
        model_reset();
        #12;
        check("rst_lanes", dut_lanes(), 128'd0);
        check("rst_valid", 128'(frame_valid), 128'd0);
        check("rst_idx", 128'(fill_idx), 128'd0);
        check("rst_cnt", 128'(frame_cnt), 128'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rst_ready", 128'(in_ready), 128'd1);

        // Back-to-back frame 1..8.
        for (int i = 1; i <= 8; i++) send(i);
        check("f1_lanes", dut_lanes(), {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8});
        check("f1_sum", 128'(dut_sum()), 128'd36);
        check("f1_valid", 128'(frame_valid), 128'd1);
        for (int i = 0; i < 3; i++) send(50);
        check("f1_hold_ready", 128'(in_ready), 128'd0);
        ack();
        check("f1_ack_lanes", dut_lanes(), 128'd0);
        check("f1_ack_cnt", 128'(frame_cnt), 128'd1);
        check("f1_ack_ready", 128'(in_ready), 128'd1);

        // All-ones frame, then a gapped frame 10..80.
        for (int i = 0; i < 8; i++) send(16'hFFFF);
        check("ff_lanes", dut_lanes(), {8{16'hFFFF}});
        ack();
        for (int i = 1; i <= 8; i++) begin
            send(10 * i);
            idle();
        end
        check("f2_sum", 128'(dut_sum()), 128'd360);
        check("f2_h", 128'(h), 128'd80);
        ack();
        check("f2_cnt", 128'(frame_cnt), 128'd3);

        // Held frame ignores incoming words until acknowledged.
        for (int i = 0; i < 8; i++) send(i + 100);
        for (int i = 0; i < 5; i++) send(99);
        check("hold_lanes", dut_lanes(), {16'd100, 16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 16'd106, 16'd107});
        step(1'b1, 99, 1'b0, 1'b1, 1'b0);
        check("hold_ack_a", 128'(a), 128'd0);
        send(99);
        check("hold_a99", 128'(a), 128'd99);
        check("hold_idx1", 128'(fill_idx), 128'd1);

        // Flush a partial frame; the word alongside FLUSH is dropped.
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        send(5); send(6); send(7);
        step(1'b1, 9, 1'b1, 1'b0, 1'b0);
        check("flush_lanes", dut_lanes(), 128'd0);
        check("flush_idx", 128'(fill_idx), 128'd0);
        check("flush_cnt", 128'(frame_cnt), 128'd4);
        for (int i = 1; i <= 8; i++) send(i * 3);
        check("post_flush_sum", 128'(dut_sum()), 128'd108);

        // FLUSH with FRAME_ACK in HOLD must not count.
        step(1'b0, 0, 1'b1, 1'b1, 1'b0);
        check("flush_ack_cnt", 128'(frame_cnt), 128'd4);
        check("flush_ack_valid", 128'(frame_valid), 128'd0);

        // Asynchronous reset after 5 words, observed before any clock edge.
        for (int i = 1; i <= 5; i++) send(i);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("arst_lanes", dut_lanes(), 128'd0);
        check("arst_valid", 128'(frame_valid), 128'd0);
        check("arst_idx", 128'(fill_idx), 128'd0);
        check("arst_cnt", 128'(frame_cnt), 128'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Five frames on the 2-bit counter wrap to 1.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) send(k * 8 + i);
            ack();
        end
        check("wrap_cnt2", 128'(frame_cnt2), 128'd1);
        check("wrap_cnt8", 128'(frame_cnt), 128'd5);

`ifdef LOADER_ZERO_PAD_EN
        send(4); send(4);
        step(1'b1, 4, 1'b0, 1'b0, 1'b1);
        check("zp_lanes", dut_lanes(), {16'd4, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
        check("zp_valid", 128'(frame_valid), 128'd1);
        check("zp_sum", 128'(dut_sum()), 128'd12);
        ack();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tree_operand_loader.md
Name: tree_operand_loader

Overview:
- Upstream feeder for the 8-input adder tree.
- Accepts a serial stream of WIDTH-bit words over a valid/ready handshake and assembles each group of eight into parallel lanes A..H.
- Holds a completed frame stable on A..H while the tree sums it, and releases the frame only when the consumer acknowledges it.
- Counts completed frames.

Parameters:
- WIDTH, 16, bit width of each data word and of each output lane; must match the adder tree's WIDTH.
- CNT_WIDTH, 8, width of the completed-frame counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  asynchronous reset, active-low.
- IN_DATA  input  WIDTH  serial operand word.
- IN_VALID  input  1  IN_DATA is valid this cycle.
- IN_READY  output  1  loader can accept a word this cycle.
- FLUSH  input  1  synchronous discard of the current frame (partial or held).
- FRAME_ACK  input  1  consumer has taken the held frame.
- A, B, C, D, E, F, G, H  output  WIDTH each  lane registers that drive adder tree inputs A..H.
- FRAME_VALID  output  1  A..H hold a complete frame.
- FILL_IDX  output  3  index of the next lane to be written (0=A .. 7=H).
- FRAME_CNT  output  CNT_WIDTH  number of frames acknowledged since reset.

Behaviour:
- Reset (RST_N low, asynchronous):
  - A..H = 0, FILL_IDX = 0, FRAME_VALID = 0, FRAME_CNT = 0.
  - State = FILL; IN_READY = 1 once RST_N deasserts.
- All outputs are registered except IN_READY, which is decoded from state: IN_READY = 1 in FILL and 0 in HOLD.
- States:
  - FILL: collecting words.
  - HOLD: frame complete, waiting for FRAME_ACK.
- FILL:
  - A word is accepted when IN_VALID && IN_READY.
  - An accepted word is written into lane FILL_IDX, and FILL_IDX increments.
  - When the accepted word goes to lane 7 (H), the next state is HOLD, FRAME_VALID = 1 from the next cycle, and FILL_IDX wraps to 0.
  - IN_VALID = 0 leaves all state unchanged; gaps between words are allowed.
- HOLD:
  - A..H are stable and IN_READY = 0, so IN_VALID is ignored.
  - FRAME_ACK sampled high moves the next state to FILL. On that edge:
    - FRAME_VALID clears;
    - A..H clear to 0;
    - FRAME_CNT increments, wrapping modulo 2^CNT_WIDTH.
  - FRAME_ACK is ignored in FILL.
- Latency:
  - Eighth word accepted at edge N gives FRAME_VALID = 1 and H valid after edge N.
  - The adder tree output is valid combinationally in the same cycle.
  - Minimum turnaround is 1 cycle: FRAME_ACK at edge M means IN_READY = 1 in cycle M+1.
- FLUSH (priority over every other input, in any state):
  - Next state = FILL, FILL_IDX = 0, A..H = 0, FRAME_VALID = 0.
  - FRAME_CNT is not incremented.
  - A word presented in a FLUSH cycle is dropped.
  - FLUSH together with FRAME_ACK in HOLD counts as FLUSH only: no increment.
- Lanes are unsigned; no arithmetic is performed in this block. Width containment of the sum is the tree's concern.
- RST_N asserted mid-frame discards the partial frame immediately.

Optional Feature:
- Macro: LOADER_ZERO_PAD_EN.
- With the macro defined:
  - Adds input port IN_LAST (1 bit).
  - An accepted word with IN_LAST = 1 in any lane closes the frame: that lane is written, the remaining lanes stay 0, and the next state is HOLD with FILL_IDX = 0.
  - IN_LAST on lane 7 behaves exactly as a normal eighth word.
- Without the macro:
  - The IN_LAST port does not exist.
  - Frames close only after eight words.

Test Plan:
- Reset then stream 1,2,3,4,5,6,7,8 with IN_VALID held high:
  - A=1 .. H=8 and FRAME_VALID=1 after the 8th edge; tree sum = 36.
  - IN_READY=0 until FRAME_ACK; after ACK, A..H=0 and FRAME_CNT=1.
- Stream eight 0xFFFF words, ack, then stream 10,20,..,80 with IN_VALID toggling every other cycle:
  - Second frame A=10 .. H=80, sum = 360; FRAME_CNT=2 after the second ACK.
- After a frame completes, hold FRAME_ACK=0 for 5 cycles while IN_VALID=1 with data 99:
  - A..H unchanged, IN_READY=0, no word absorbed; the word 99 is accepted as lane A only after ACK.
- Send 3 words (5,6,7), then pulse FLUSH with IN_VALID=1 and data 9:
  - A..H=0, FILL_IDX=0, FRAME_CNT unchanged, word 9 dropped.
  - A following 8-word frame fills correctly.
- With CNT_WIDTH=2, complete and ack 5 frames: FRAME_CNT reads 1 (wrap).
- With LOADER_ZERO_PAD_EN defined, send 4,4,4 with IN_LAST on the third word:
  - A=B=C=4, D..H=0, FRAME_VALID=1, sum = 12.
- Assert RST_N low mid-frame (after 5 words): all outputs 0 immediately, without waiting for a clock edge.
